// File: rtl/prio_pkg.sv
// Shared types and encodings for the priority-encoder arbiter.
package prio_pkg;

    // Arbiter FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Values of the mode input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational winner search: the first set request found walking downward
// from start, wrapping from index 0 back to N-1.
module prio_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    int           c;
    logic [W-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest set bit wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        c     = 0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = int'(start) - i;
            if (c < 0) begin
                c = c + N;
            end
            cand = W'(c);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_enc_arb.sv
// Priority-encoder arbiter with fixed-priority and round-robin modes and a
// valid/ready handshake on the registered grant.
module prio_enc_arb #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] din,
    input  logic         ready,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [N-1:0] onehot
);
    import prio_pkg::*;

    localparam logic [W-1:0] LAST = W'(N - 1);

    state_t       state_q, state_d;
    logic [W-1:0] dout_q;
    logic [N-1:0] onehot_q;
    logic [W-1:0] ptr_q;
    logic         mode_q;

    logic [W-1:0] start;
    logic [W-1:0] pick_idx;
    logic         pick_found;
    logic [N-1:0] pick_vec;
    logic         take;
    logic         hs;
    logic         abort;

    // Fixed priority always searches from the top index
    assign start = (mode == MODE_RR) ? ptr_q : LAST;

    prio_pick #(
        .N(N),
        .W(W)
    ) u_pick (
        .req  (din),
        .start(start),
        .idx  (pick_idx),
        .found(pick_found)
    );

    // Event decode; an abort (en low) overrides a same-cycle ready
    always_comb begin
        take     = (state_q == IDLE) && en && pick_found;
        hs       = (state_q == GRANT) && en && ready;
        abort    = (state_q == GRANT) && !en;
        pick_vec = '0;
        pick_vec[pick_idx] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = GRANT;
            GRANT:   if (!en || ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant data, latched mode and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q   <= '0;
            onehot_q <= '0;
            ptr_q    <= LAST;
            mode_q   <= MODE_FIXED;
        end else begin
            if (take) begin
                dout_q   <= pick_idx;
                onehot_q <= pick_vec;
                mode_q   <= mode;
            end else if (hs || abort) begin
                onehot_q <= '0;
            end
            // Mode latched at grant time decides whether the pointer advances
            if (hs && (mode_q == MODE_RR)) begin
                ptr_q <= (dout_q == '0) ? LAST : dout_q - W'(1);
            end
        end
    end

    // Outputs straight from flops
    always_comb begin
        valid  = (state_q == GRANT);
        dout   = dout_q;
        onehot = onehot_q;
    end

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed self-checking bench for prio_enc_arb with N=8.
module tb_prio_enc_arb;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         mode;
    logic [N-1:0] din;
    logic         ready;
    logic [W-1:0] dout;
    logic         valid;
    logic [N-1:0] onehot;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] din;
        logic [2:0] idx;
        logic [7:0] oh;
    } vec_t;

    vec_t vecs[7];

    prio_enc_arb #(
        .N(N)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .din   (din),
        .ready (ready),
        .dout  (dout),
        .valid (valid),
        .onehot(onehot)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        mode  = 1'b0;
        ready = 1'b0;
        din   = '0;
        #12;
        rst = 1'b0;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_onehot", 32'(onehot), 32'd0);

        // Fixed-priority vectors: highest set bit wins
        vecs[0] = '{din: 8'h50, idx: 3'd6, oh: 8'h40};
        vecs[1] = '{din: 8'h01, idx: 3'd0, oh: 8'h01};
        vecs[2] = '{din: 8'h80, idx: 3'd7, oh: 8'h80};
        vecs[3] = '{din: 8'hFF, idx: 3'd7, oh: 8'h80};
        vecs[4] = '{din: 8'h03, idx: 3'd1, oh: 8'h02};
        vecs[5] = '{din: 8'h24, idx: 3'd5, oh: 8'h20};
        vecs[6] = '{din: 8'h10, idx: 3'd4, oh: 8'h10};

        for (int v = 0; v < 7; v++) begin
            en    = 1'b1;
            mode  = 1'b0;
            din   = vecs[v].din;
            ready = 1'b0;
            tick();
            check($sformatf("fix%0d_valid", v), 32'(valid), 32'd1);
            check($sformatf("fix%0d_dout", v), 32'(dout), 32'(vecs[v].idx));
            check($sformatf("fix%0d_onehot", v), 32'(onehot), 32'(vecs[v].oh));
            ready = 1'b1;
            din   = '0;
            tick();
            check($sformatf("fix%0d_drop", v), 32'(valid), 32'd0);
            check($sformatf("fix%0d_oh0", v), 32'(onehot), 32'd0);
            check($sformatf("fix%0d_hold", v), 32'(dout), 32'(vecs[v].idx));
            ready = 1'b0;
        end

        // Round-robin sweep with din all ones and ready held high
        mode  = 1'b1;
        din   = 8'hFF;
        ready = 1'b1;
        en    = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("rr%0d_valid", k), 32'(valid), 32'd1);
            check($sformatf("rr%0d_dout", k), 32'(dout), (k < 8) ? 32'(7 - k) : 32'd7);
            tick();
            check($sformatf("rr%0d_gap", k), 32'(valid), 32'd0);
        end
        en    = 1'b0;
        din   = '0;
        ready = 1'b0;

        // Held grant survives din and mode changes until ready
        en   = 1'b1;
        mode = 1'b0;
        din  = 8'h08;
        tick();
        check("hold_dout0", 32'(dout), 32'd3);
        din  = 8'h80;
        mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold%0d_valid", k), 32'(valid), 32'd1);
            check($sformatf("hold%0d_dout", k), 32'(dout), 32'd3);
            check($sformatf("hold%0d_onehot", k), 32'(onehot), 32'h08);
        end
        ready = 1'b1;
        din   = '0;
        tick();
        check("hold_release", 32'(valid), 32'd0);
        ready = 1'b0;

        // Winner 0 in round-robin wraps the pointer to 7
        mode = 1'b1;
        din  = 8'h01;
        tick();
        check("wrap_dout", 32'(dout), 32'd0);
        ready = 1'b1;
        din   = '0;
        tick();
        ready = 1'b0;
        din   = 8'h20;
        tick();
        check("abort_grant", 32'(dout), 32'd5);
        check("abort_valid1", 32'(valid), 32'd1);
        // Abort with a simultaneous ready must not advance the pointer
        en    = 1'b0;
        ready = 1'b1;
        tick();
        check("abort_valid0", 32'(valid), 32'd0);
        ready = 1'b0;
        en    = 1'b1;
        din   = 8'hFF;
        tick();
        check("abort_ptr_kept", 32'(dout), 32'd7);
        ready = 1'b1;
        din   = '0;
        tick();
        ready = 1'b0;
        din   = 8'hFF;
        tick();
        check("pre_rst_dout", 32'(dout), 32'd6);
        check("pre_rst_valid", 32'(valid), 32'd1);

        // Asynchronous reset in the middle of a grant
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_dout", 32'(dout), 32'd0);
        check("arst_onehot", 32'(onehot), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        check("arst_ptr7", 32'(dout), 32'd7);
        check("arst_regrant", 32'(valid), 32'd1);
        ready = 1'b1;
        din   = '0;
        tick();
        check("arst_done", 32'(valid), 32'd0);
        ready = 1'b0;

        // No requests: stays idle
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("idle%0d_valid", k), 32'(valid), 32'd0);
        end
        check("idle_dout_kept", 32'(dout), 32'd7);
        en  = 1'b0;
        din = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("dis%0d_valid", k), 32'(valid), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
